// File: rtl/mac_lane_feeder.sv
// Operand feeder for mac_lane: packs a serial activation/weight stream into
// 16-wide vectors, issues each for one cycle, then drains and clears the lane.
module mac_lane_feeder #(
  parameter int IL    = 8,
  parameter int FL    = 12,
  parameter int DRAIN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IL+FL-1:0] in_i,
  input  logic [IL+FL-1:0] in_w,
  input  logic             in_last,
  output logic [IL+FL-1:0] i_0,  i_1,  i_2,  i_3,
  output logic [IL+FL-1:0] i_4,  i_5,  i_6,  i_7,
  output logic [IL+FL-1:0] i_8,  i_9,  i_10, i_11,
  output logic [IL+FL-1:0] i_12, i_13, i_14, i_15,
  output logic [IL+FL-1:0] w_0,  w_1,  w_2,  w_3,
  output logic [IL+FL-1:0] w_4,  w_5,  w_6,  w_7,
  output logic [IL+FL-1:0] w_8,  w_9,  w_10, w_11,
  output logic [IL+FL-1:0] w_12, w_13, w_14, w_15,
  output logic             issue,
  output logic             result_valid,
  output logic             lane_rst,
  output logic             busy
);

  localparam int W  = IL + FL;
  localparam int DW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [W-1:0]    r_act [16];
  logic [W-1:0]    r_wgt [16];
  logic            r_last;
  logic [DW-1:0]   r_drain;

  logic            w_rdy;
  logic            w_iss;
  logic            w_done;
  logic            w_accept;
  logic            w_complete;
  logic [W-1:0]    w_iv [16];
  logic [W-1:0]    w_wv [16];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b0;
    w_iss  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_rdy = 1'b1;
        if (in_valid && (r_cnt == 4'd15 || in_last))
          w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_iss  = 1'b1;
        w_next = r_last ? S_DRAIN : S_FILL;
      end
      S_DRAIN: begin
        if (r_drain == '0) begin
          w_done = 1'b1;
          w_next = S_FILL;
        end
      end
      default: w_next = S_FILL;
    endcase
  end

  // Outputs come from registered state only; reset forces them low.
  assign in_ready     = w_rdy  & ~reset;
  assign issue        = w_iss  & ~reset;
  assign result_valid = w_done & ~reset;
  assign lane_rst     = w_done & ~reset;
  assign busy         = ~reset &
                        ~(r_state == S_FILL && r_cnt == 4'd0);

  assign w_accept   = in_valid & in_ready;
  assign w_complete = w_accept & (r_cnt == 4'd15 || in_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_drain <= '0;
      for (int k = 0; k < 16; k++) begin
        r_act[k] <= '0;
        r_wgt[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_cnt  <= r_cnt + 4'd1;
        r_last <= in_last;
        for (int k = 0; k < 16; k++) begin
          if (k == int'(r_cnt)) begin
            r_act[k] <= in_i;
            r_wgt[k] <= in_w;
          end else if (w_complete && k > int'(r_cnt)) begin
            r_act[k] <= '0;
            r_wgt[k] <= '0;
          end
        end
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
        for (int k = 0; k < 16; k++) begin
          r_act[k] <= '0;
          r_wgt[k] <= '0;
        end
        if (r_last) r_drain <= DW'(DRAIN - 1);
      end
      if (r_state == S_DRAIN) begin
        if (r_drain == '0) r_last  <= 1'b0;
        else               r_drain <= r_drain - 1'b1;
      end
    end
  end

  // Idle cycles present zeros so the lane accumulator holds.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_iv[k] = issue ? r_act[k] : '0;
      w_wv[k] = issue ? r_wgt[k] : '0;
    end
  end

  assign i_0  = w_iv[0];
  assign i_1  = w_iv[1];
  assign i_2  = w_iv[2];
  assign i_3  = w_iv[3];
  assign i_4  = w_iv[4];
  assign i_5  = w_iv[5];
  assign i_6  = w_iv[6];
  assign i_7  = w_iv[7];
  assign i_8  = w_iv[8];
  assign i_9  = w_iv[9];
  assign i_10 = w_iv[10];
  assign i_11 = w_iv[11];
  assign i_12 = w_iv[12];
  assign i_13 = w_iv[13];
  assign i_14 = w_iv[14];
  assign i_15 = w_iv[15];
  assign w_0  = w_wv[0];
  assign w_1  = w_wv[1];
  assign w_2  = w_wv[2];
  assign w_3  = w_wv[3];
  assign w_4  = w_wv[4];
  assign w_5  = w_wv[5];
  assign w_6  = w_wv[6];
  assign w_7  = w_wv[7];
  assign w_8  = w_wv[8];
  assign w_9  = w_wv[9];
  assign w_10 = w_wv[10];
  assign w_11 = w_wv[11];
  assign w_12 = w_wv[12];
  assign w_13 = w_wv[13];
  assign w_14 = w_wv[14];
  assign w_15 = w_wv[15];

endmodule

// File: tb/tb_mac_lane_feeder.sv
// Bench for mac_lane_feeder: random pair streams checked against a chunked
// vector model and a behavioural lane accumulator.
module tb_mac_lane_feeder;
  localparam int IL = 8, FL = 12, DRAIN = 8, W = IL + FL;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [W-1:0] in_i = '0, in_w = '0;
  logic in_ready, issue, result_valid, lane_rst, busy;
  logic [W-1:0] i_0, i_1, i_2, i_3, i_4, i_5, i_6, i_7;
  logic [W-1:0] i_8, i_9, i_10, i_11, i_12, i_13, i_14, i_15;
  logic [W-1:0] w_0, w_1, w_2, w_3, w_4, w_5, w_6, w_7;
  logic [W-1:0] w_8, w_9, w_10, w_11, w_12, w_13, w_14, w_15;

  mac_lane_feeder #(.IL(IL), .FL(FL), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_w(in_w), .in_last(in_last),
    .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
    .i_4(i_4), .i_5(i_5), .i_6(i_6), .i_7(i_7),
    .i_8(i_8), .i_9(i_9), .i_10(i_10), .i_11(i_11),
    .i_12(i_12), .i_13(i_13), .i_14(i_14), .i_15(i_15),
    .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .w_4(w_4), .w_5(w_5), .w_6(w_6), .w_7(w_7),
    .w_8(w_8), .w_9(w_9), .w_10(w_10), .w_11(w_11),
    .w_12(w_12), .w_13(w_13), .w_14(w_14), .w_15(w_15),
    .issue(issue), .result_valid(result_valid),
    .lane_rst(lane_rst), .busy(busy));

  always #5 clk = ~clk;

  wire [16*W-1:0] va = {i_15, i_14, i_13, i_12, i_11, i_10, i_9, i_8,
                        i_7, i_6, i_5, i_4, i_3, i_2, i_1, i_0};
  wire [16*W-1:0] vb = {w_15, w_14, w_13, w_12, w_11, w_10, w_9, w_8,
                        w_7, w_6, w_5, w_4, w_3, w_2, w_1, w_0};

  int checks = 0, failures = 0, cyc = 0, leak = 0, plsmis = 0;
  int acc_q[$], iss_cyc[$], rv_cyc[$];
  logic [16*W-1:0] iss_a[$], iss_b[$];
  longint rv_f[$];
  longint lacc = 0;
  logic [W-1:0] pa[$], pb[$];

  // Accept log: in_ready seen here is the pre-edge value.
  always @(posedge clk) begin
    cyc++;
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
  end

  // Lane model: accumulates truncated products, clears on lane reset.
  always @(negedge clk) begin
    if (reset) lacc = 0;
    else begin
      if (issue) begin
        iss_cyc.push_back(cyc);
        iss_a.push_back(va);
        iss_b.push_back(vb);
        for (int k = 0; k < 16; k++)
          lacc += (longint'($signed(va[k*W +: W])) *
                   longint'($signed(vb[k*W +: W]))) >>> FL;
      end else if (va != '0 || vb != '0) leak++;
      if (lane_rst !== result_valid) plsmis++;
      if (result_valid) begin
        rv_cyc.push_back(cyc);
        rv_f.push_back(lacc);
        lacc = 0;
      end
    end
  end

  function automatic longint ref_f();
    longint s = 0;
    foreach (pa[j])
      s += (longint'($signed(pa[j])) * longint'($signed(pb[j]))) >>> FL;
    return s;
  endfunction

  function automatic logic [16*W-1:0] ref_vec(input int c, input bit act);
    logic [16*W-1:0] v = '0;
    for (int s = 0; s < 16; s++)
      if (16*c + s < pa.size())
        v[s*W +: W] = act ? pa[16*c + s] : pb[16*c + s];
    return v;
  endfunction

  task automatic clr();
    acc_q.delete(); iss_cyc.delete(); rv_cyc.delete();
    iss_a.delete(); iss_b.delete(); rv_f.delete();
    leak = 0; plsmis = 0;
  endtask

  task automatic rnd_pairs(input int n);
    pa.delete(); pb.delete();
    for (int j = 0; j < n; j++) begin
      pa.push_back(W'($urandom));
      pb.push_back(W'($urandom));
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic last, input int gap);
    int t = 0;
    bit ok = 0;
    if (gap > 0) begin
      in_valid = 0; in_last = 0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1; in_i = a; in_w = b; in_last = last;
    while (!ok && t < 400) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout in_ready=0 after %0d cycles, want 1", t);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_rv(input int k);
    int t = 0;
    while (rv_cyc.size() < k && t < DRAIN + 60) begin
      @(posedge clk); #1; t++;
    end
  endtask

  task automatic run(input int gapmax);
    foreach (pa[j])
      send(pa[j], pb[j], j == pa.size() - 1, $urandom_range(0, gapmax));
    wait_rv(1);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, issue, result_valid, lane_rst, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {in_ready, issue, result_valid, lane_rst, busy});
    end
    checks++;
    if (va !== '0 || vb !== '0) begin
      failures++; $display("FAIL reset_vec got=%h/%h want=0", va, vb);
    end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL post_reset ready,busy got=%b want=10", {in_ready, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full16();
    clr(); pa.delete(); pb.delete();
    for (int j = 0; j < 16; j++) begin
      pa.push_back(W'(4096)); pb.push_back(W'(4096));
    end
    run(0);
    checks++;
    if (iss_cyc.size() != 1 || acc_q.size() != 16) begin
      failures++;
      $display("FAIL full16_count issues=%0d accepts=%0d want 1/16",
               iss_cyc.size(), acc_q.size());
    end else begin
      checks++;
      if (acc_q[15] - acc_q[0] != 15) begin
        failures++; $display("FAIL full16_b2b span=%0d want=15", acc_q[15] - acc_q[0]);
      end
      checks++;
      if (iss_cyc[0] != acc_q[15]) begin
        failures++;
        $display("FAIL full16_latency issue=%0d want=%0d", iss_cyc[0], acc_q[15]);
      end
      checks++;
      if (iss_a[0] !== ref_vec(0, 1) || iss_b[0] !== ref_vec(0, 0)) begin
        failures++; $display("FAIL full16_vec got=%h want=%h", iss_a[0], ref_vec(0, 1));
      end
    end
    checks++;
    if (rv_cyc.size() != 1 || iss_cyc.size() == 0) begin
      failures++; $display("FAIL full16_rv count=%0d want=1", rv_cyc.size());
    end else begin
      checks++;
      if (rv_cyc[0] != iss_cyc[0] + DRAIN) begin
        failures++;
        $display("FAIL full16_drain rv=%0d want=%0d", rv_cyc[0], iss_cyc[0] + DRAIN);
      end
      checks++;
      if (rv_f[0] != 65536) begin
        failures++; $display("FAIL full16_f got=%0d want=65536", rv_f[0]);
      end
    end
    checks++;
    if (leak != 0 || plsmis != 0) begin
      failures++; $display("FAIL full16_idle leak=%0d pulse=%0d want 0/0", leak, plsmis);
    end
  endtask

  task automatic test_small3();
    clr(); pa.delete(); pb.delete();
    pa = '{W'(1), W'(2), W'(3)};
    pb = '{W'(2), W'(3), W'(4)};
    run(1);
    checks++;
    if (iss_cyc.size() != 1 || rv_cyc.size() != 1) begin
      failures++;
      $display("FAIL small3_count issues=%0d rv=%0d want 1/1", iss_cyc.size(), rv_cyc.size());
    end else begin
      checks++;
      if (iss_a[0] !== ref_vec(0, 1) || iss_b[0] !== ref_vec(0, 0)) begin
        failures++;
        $display("FAIL small3_vec got=%h/%h want=%h/%h",
                 iss_a[0], iss_b[0], ref_vec(0, 1), ref_vec(0, 0));
      end
      checks++;
      if (rv_cyc[0] != iss_cyc[0] + DRAIN) begin
        failures++;
        $display("FAIL small3_drain rv=%0d want=%0d", rv_cyc[0], iss_cyc[0] + DRAIN);
      end
    end
  endtask

  task automatic test_twenty();
    clr(); rnd_pairs(20);
    run(2);
    checks++;
    if (iss_cyc.size() != 2 || rv_cyc.size() != 1 || acc_q.size() != 20) begin
      failures++;
      $display("FAIL twenty_count issues=%0d rv=%0d acc=%0d want 2/1/20",
               iss_cyc.size(), rv_cyc.size(), acc_q.size());
    end else begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (iss_a[c] !== ref_vec(c, 1) || iss_b[c] !== ref_vec(c, 0)) begin
          failures++; $display("FAIL twenty_vec%0d got=%h want=%h", c, iss_a[c], ref_vec(c, 1));
        end
      end
      checks++;
      if (iss_cyc[0] != acc_q[15] || iss_cyc[1] != acc_q[19]) begin
        failures++;
        $display("FAIL twenty_issue_cyc got=%0d,%0d want=%0d,%0d",
                 iss_cyc[0], iss_cyc[1], acc_q[15], acc_q[19]);
      end
      checks++;
      if (rv_cyc[0] != iss_cyc[1] + DRAIN) begin
        failures++;
        $display("FAIL twenty_drain rv=%0d want=%0d", rv_cyc[0], iss_cyc[1] + DRAIN);
      end
      checks++;
      if (rv_f[0] != ref_f()) begin
        failures++; $display("FAIL twenty_f got=%0d want=%0d", rv_f[0], ref_f());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    clr(); rnd_pairs(16);
    x = W'($urandom); y = W'($urandom);
    foreach (pa[j]) send(pa[j], pb[j], j == 15, 0);
    send(x, y, 1, 0);
    wait_rv(2);
    checks++;
    if (acc_q.size() != 17 || rv_cyc.size() != 2 || iss_cyc.size() != 2) begin
      failures++;
      $display("FAIL hold_count acc=%0d rv=%0d iss=%0d want 17/2/2",
               acc_q.size(), rv_cyc.size(), iss_cyc.size());
    end else begin
      checks++;
      if (acc_q[16] != rv_cyc[0] + 2) begin
        failures++;
        $display("FAIL hold_accept_cyc got=%0d want=%0d", acc_q[16], rv_cyc[0] + 2);
      end
      checks++;
      if (iss_a[1] !== (16*W)'(x) || iss_b[1] !== (16*W)'(y)) begin
        failures++;
        $display("FAIL hold_slot0 got=%h/%h want=%h/%h", iss_a[1], iss_b[1], x, y);
      end
      checks++;
      if (iss_a[0] !== ref_vec(0, 1)) begin
        failures++; $display("FAIL hold_first_vec got=%h want=%h", iss_a[0], ref_vec(0, 1));
      end
    end
    checks++;
    if (leak != 0) begin
      failures++; $display("FAIL hold_leak got=%0d want=0", leak);
    end
  endtask

  task automatic test_reset_mid();
    clr(); rnd_pairs(7);
    for (int j = 0; j < 7; j++) send(pa[j], pb[j], 0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy got=%b want=1", busy);
    end
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    checks++;
    if ({in_ready, issue, result_valid, lane_rst, busy} !== 5'b0 ||
        va !== '0 || vb !== '0) begin
      failures++;
      $display("FAIL mid_reset_out got=%b want=00000",
               {in_ready, issue, result_valid, lane_rst, busy});
    end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10 || rv_cyc.size() != 0 || iss_cyc.size() != 0) begin
      failures++;
      $display("FAIL mid_after ready,busy=%b rv=%0d iss=%0d want 10/0/0",
               {in_ready, busy}, rv_cyc.size(), iss_cyc.size());
    end
    @(posedge clk); #1;
    clr(); rnd_pairs(16);
    for (int j = 0; j < 16; j++) begin
      send(pa[j], pb[j], j == 15, 0);
      if (j == 8) begin
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (iss_cyc.size() != 0) begin
          failures++; $display("FAIL mid_early_issue got=%0d want=0", iss_cyc.size());
        end
      end
    end
    wait_rv(1);
    checks++;
    if (iss_cyc.size() != 1 || rv_cyc.size() != 1) begin
      failures++;
      $display("FAIL mid_fresh_count iss=%0d rv=%0d want 1/1", iss_cyc.size(), rv_cyc.size());
    end else if (iss_a[0] !== ref_vec(0, 1) || iss_b[0] !== ref_vec(0, 0)) begin
      failures++; $display("FAIL mid_fresh_vec got=%h want=%h", iss_a[0], ref_vec(0, 1));
    end
  endtask

  task automatic test_last_at_15();
    clr(); rnd_pairs(16);
    run(1);
    repeat (DRAIN + 10) @(posedge clk);
    #1;
    checks++;
    if (iss_cyc.size() != 1 || rv_cyc.size() != 1) begin
      failures++;
      $display("FAIL l15_count iss=%0d rv=%0d want 1/1", iss_cyc.size(), rv_cyc.size());
    end else begin
      checks++;
      if (rv_cyc[0] != iss_cyc[0] + DRAIN || iss_a[0] !== ref_vec(0, 1)) begin
        failures++;
        $display("FAIL l15_issue rv=%0d want=%0d", rv_cyc[0], iss_cyc[0] + DRAIN);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n, ni;
      n = $urandom_range(1, 40);
      ni = (n + 15) / 16;
      clr(); rnd_pairs(n);
      run(3);
      checks++;
      if (iss_cyc.size() != ni || rv_cyc.size() != 1) begin
        failures++;
        $display("FAIL rnd%0d_count n=%0d iss=%0d rv=%0d want %0d/1",
                 it, n, iss_cyc.size(), rv_cyc.size(), ni);
        continue;
      end
      for (int c = 0; c < ni; c++) begin
        checks++;
        if (iss_a[c] !== ref_vec(c, 1) || iss_b[c] !== ref_vec(c, 0)) begin
          failures++;
          $display("FAIL rnd%0d_vec%0d got=%h want=%h", it, c, iss_a[c], ref_vec(c, 1));
        end
      end
      checks++;
      if (rv_cyc[0] != iss_cyc[ni-1] + DRAIN || rv_f[0] != ref_f()) begin
        failures++;
        $display("FAIL rnd%0d_result rv=%0d f=%0d want %0d/%0d",
                 it, rv_cyc[0], rv_f[0], iss_cyc[ni-1] + DRAIN, ref_f());
      end
      checks++;
      if (leak != 0 || plsmis != 0) begin
        failures++;
        $display("FAIL rnd%0d_idle leak=%0d pulse=%0d want 0/0", it, leak, plsmis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full16();
    test_small3();
    test_twenty();
    test_back_to_back();
    test_reset_mid();
    test_last_at_15();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
